usb_tx_timer: RTL
=================

USB_TX_TIMER -- requirements
Module: usb_tx_timer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port enable_timer, input, 1: high while the packet is being sent; starts and sustains bit timing.
REQ-004 SHALL have port stuff_bit, input, 1: encoder flag; the current bit period carries a stuffed bit that is not counted as data.
REQ-005 SHALL have port bit_strobe, output, 1: one-cycle pulse at each bit boundary; the encoder shifts out the next bit.
REQ-006 SHALL have port byte_done, output, 1: one-cycle pulse when the 8th data bit of a byte completes; the encoder loads the next byte.
REQ-007 SHALL have port bit_index, output, 3: number of data bits sent so far in the current byte (0-7).
REQ-008 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-009 SHALL implement states IDLE and SEND, plus EOP when TX_EOP_TIMER_EN is defined.
REQ-010 IDLE->SEND SHALL occur on the first clk edge with enable_timer=1; phase count becomes 1 on that edge.
REQ-011 In SEND, phase count SHALL increment by 1 per clk, 1..25; after 25 the next value is 1 (25 clocks = 3 bits at 8.33 clk/bit).
REQ-012 bit_strobe SHALL be high exactly in cycles where state=SEND and phase count is 8, 16 or 25.
REQ-013 On a bit_strobe cycle with stuff_bit=0, bit_index SHALL increment at the next edge; with stuff_bit=1 it SHALL hold.
REQ-014 byte_done SHALL be high in the bit_strobe cycle where bit_index=7 and stuff_bit=0; bit_index then wraps to 0.
REQ-015 stuff_bit SHALL be ignored outside bit_strobe cycles.
REQ-016 SEND with enable_timer=0 SHALL go to IDLE at the next edge, clearing phase count and bit_index to 0.
REQ-017 A strobe and byte_done that fall in the same cycle as enable_timer falling SHALL still be issued; no further strobes follow.
REQ-018 IDLE SHALL hold all counters at 0 and all outputs low.
REQ-019 Phase counter width SHALL be 5 bits; values 0 and 26-31 are unreachable in SEND.

Reset
REQ-020 rst=1 SHALL force state IDLE, phase count 0 and bit_index 0 immediately, independent of clk.
REQ-021 During reset, bit_strobe, byte_done and busy SHALL be 0; bit_index SHALL be 0.
REQ-022 Reset asserted mid-byte SHALL discard progress; after release, the first strobe occurs 8 clocks after enable_timer is sampled high.

Configuration
REQ-023 Macro TX_EOP_TIMER_EN SHALL, when defined, add input eop_start (1 bit) and output eop_done (1 bit).
REQ-024 With TX_EOP_TIMER_EN defined: eop_start=1 in SEND SHALL enter EOP at the next edge and restart phase at 1; eop_start has priority over enable_timer=0.
REQ-025 In EOP, bit_strobe SHALL follow the 8/16/25 rule; bit_index and byte_done SHALL stay 0; stuff_bit SHALL be ignored.
REQ-026 eop_done SHALL pulse in the 3rd EOP strobe (2 SE0 bits + 1 J bit); the state then goes to IDLE.
REQ-027 Without TX_EOP_TIMER_EN, the eop ports SHALL be absent and the EOP state SHALL not exist.

Structure
REQ-028 Package usb_tx_pkg SHALL hold the state enum and constants: BIT_FRAME_LEN=25, STROBE_PH0=8, STROBE_PH1=16, STROBE_PH2=25, BITS_PER_BYTE=8, EOP_BITS=3.
REQ-029 Sub-module tx_phase_counter SHALL provide the 1..25 wrap counter with clear and enable, instantiated once.

Verification
REQ-030 Bench SHALL cover: reset, then enable_timer=1 held for 100 clk -> strobes at cycles 8, 16, 25, 33, 41, 50, 58, 66; byte_done on the 8th strobe (cycle 66).
REQ-031 Bench SHALL cover: stuff_bit=1 on the 3rd strobe only -> byte_done moves to the 9th strobe (cycle 75); bit_index holds at 2 across the stuffed strobe.
REQ-032 Bench SHALL cover: enable_timer dropped at cycle 20 -> busy=0 by cycle 21; no strobe after cycle 16; bit_index=0.
REQ-033 Bench SHALL cover: rst pulsed at cycle 30 of SEND -> outputs 0 asynchronously; re-enable -> first strobe 8 clocks later with bit_index=0.
REQ-034 Bench SHALL cover, with TX_EOP_TIMER_EN: eop_start at cycle 66 -> EOP strobes 8, 16 and 25 clocks later; eop_done with the 3rd strobe; IDLE next cycle.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding and bit-timing constants for the USB TX timer.
// Optional feature macro: TX_EOP_TIMER_EN (adds the EOP state).
package usb_tx_pkg;

  localparam int unsigned PHASE_W = 5;

  // 25 clocks carry exactly 3 bits at 8.33 clk/bit; strobes land on these phases.
  localparam logic [PHASE_W-1:0] BIT_FRAME_LEN = 5'd25;
  localparam logic [PHASE_W-1:0] STROBE_PH0    = 5'd8;
  localparam logic [PHASE_W-1:0] STROBE_PH1    = 5'd16;
  localparam logic [PHASE_W-1:0] STROBE_PH2    = 5'd25;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned EOP_BITS      = 3;

`ifdef TX_EOP_TIMER_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    EOP  = 2'd2
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } tx_state_t;
`endif

  function automatic logic is_strobe_phase(input logic [PHASE_W-1:0] ph);
    return (ph == STROBE_PH0) || (ph == STROBE_PH1) || (ph == STROBE_PH2);
  endfunction

endpackage

// File: rtl/tx_phase_counter.sv
// tx_phase_counter: 1..BIT_FRAME_LEN wrapping phase counter with clear, restart and advance.
module tx_phase_counter
  import usb_tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               restart,
  input  logic               advance,
  output logic [PHASE_W-1:0] phase
);

  // Phase register: clear wins, restart reloads 1, advance wraps 25 -> 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (restart) begin
      phase <= 5'd1;
    end else if (advance) begin
      phase <= (phase == BIT_FRAME_LEN) ? 5'd1 : phase + 5'd1;
    end
  end

endmodule

// File: rtl/usb_tx_timer.sv
// usb_tx_timer: bit/byte timing for the USB transmit encoder.
// Optional feature macro: TX_EOP_TIMER_EN (adds eop_start/eop_done and the EOP state).
module usb_tx_timer
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_timer,
  input  logic       stuff_bit,
  output logic       bit_strobe,
  output logic       byte_done,
  output logic [2:0] bit_index,
  output logic       busy
`ifdef TX_EOP_TIMER_EN
  ,
  input  logic       eop_start,
  output logic       eop_done
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic [PHASE_W-1:0] phase;
  logic               strobe_ph;
  logic               ph_clear;
  logic               ph_restart;
  logic               ph_advance;
  logic               data_strobe;

  assign strobe_ph   = is_strobe_phase(phase);
  assign data_strobe = (state_q == SEND) && strobe_ph && !stuff_bit;

`ifdef TX_EOP_TIMER_EN
  localparam logic [1:0] EOP_LAST = 2'(EOP_BITS - 1);

  logic [1:0] eop_cnt;
  logic       eop_last;

  assign eop_last = (state_q == EOP) && strobe_ph && (eop_cnt == EOP_LAST);

  // Count EOP strobes so the final (J) bit can be recognised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eop_cnt <= '0;
    end else if (state_q != EOP) begin
      eop_cnt <= '0;
    end else if (strobe_ph) begin
      eop_cnt <= eop_cnt + 2'd1;
    end
  end

  assign ph_restart = (state_q == SEND) && (state_d == EOP);
`else
  assign ph_restart = 1'b0;
`endif

  assign ph_clear   = (state_d == IDLE);
  assign ph_advance = (state_d != IDLE);

  tx_phase_counter u_phase (
    .clk     (clk),
    .rst     (rst),
    .clear   (ph_clear),
    .restart (ph_restart),
    .advance (ph_advance),
    .phase   (phase)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; eop_start outranks a falling enable_timer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable_timer) state_d = SEND;
      end
      SEND: begin
`ifdef TX_EOP_TIMER_EN
        if (eop_start)          state_d = EOP;
        else if (!enable_timer) state_d = IDLE;
`else
        if (!enable_timer)      state_d = IDLE;
`endif
      end
`ifdef TX_EOP_TIMER_EN
      EOP: begin
        if (eop_last) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode from current state, phase and bit position.
  always_comb begin
    busy       = (state_q != IDLE);
    bit_strobe = (state_q != IDLE) && strobe_ph;
    byte_done  = data_strobe && (bit_index == LAST_BIT);
`ifdef TX_EOP_TIMER_EN
    eop_done   = eop_last;
`endif
  end

  // Data-bit position: counts unstuffed strobes, cleared whenever SEND is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_index <= '0;
    end else if (state_d != SEND) begin
      bit_index <= '0;
    end else if (data_strobe) begin
      bit_index <= (bit_index == LAST_BIT) ? '0 : bit_index + 3'd1;
    end
  end

endmodule
